sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl.sv | 112 +++++++++++
 tb/tb_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// Sweep controller: drives an external 16-bit up/down counter from its current value
// home to zero, then through a set number of 0 -> limit -> 0 sweeps, then pulses done.
module sweep_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] limit,
    input  logic [3:0]  sweeps,
    input  logic [15:0] cnt_in,
    output logic        s,
    output logic        cnt_en,
    output logic        busy,
    output logic        done,
    output logic [3:0]  sweep_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StHome,
        StUp,
        StDown,
        StDone
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] limit_q, limit_d;
    logic [3:0]  sweeps_q, sweeps_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  idx_inc;

    assign idx_inc   = idx_q + 4'd1;
    assign sweep_idx = idx_q;

    // State, job parameters and sweep counter; parameters only load on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            limit_q  <= 16'd0;
            sweeps_q <= 4'd0;
            idx_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            sweeps_q <= sweeps_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state and counter controls; abort overrides every transition and kills cnt_en
    // in the same cycle so the counter cannot take one more step.
    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        sweeps_d = sweeps_q;
        idx_d    = idx_q;
        s        = 1'b0;
        cnt_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    limit_d  = limit;
                    sweeps_d = sweeps;
                    idx_d    = 4'd0;
                    state_d  = StHome;
                end
            end
            StHome: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_in != 16'd0) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = (sweeps_q != 4'd0) ? StUp : StDone;
                end
            end
            StUp: begin
                busy = 1'b1;
                s    = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_in != limit_q) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = StDown;
                end
            end
            StDown: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_in != 16'd0) begin
                    cnt_en = 1'b1;
                end else begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == sweeps_q) ? StDone : StUp;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a behavioural enabled up/down counter closes the loop, and each
// job is checked cycle by cycle against an expected trace built from the sweep rules.
module tb_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] limit_in;
    logic [3:0]  sweeps_in;
    logic [15:0] cnt;
    logic        s;
    logic        cnt_en;
    logic        busy;
    logic        done;
    logic [3:0]  sweep_idx;

    logic        load;
    logic [15:0] load_val;

    int total;
    int bad;
    int job_no;

    typedef struct {
        logic        s;
        logic        en;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];

    sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .limit     (limit_in),
        .sweeps    (sweeps_in),
        .cnt_in    (cnt),
        .s         (s),
        .cnt_en    (cnt_en),
        .busy      (busy),
        .done      (done),
        .sweep_idx (sweep_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled counter: preloadable, steps by one in direction s when enabled.
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (cnt_en) cnt <= s ? cnt + 16'd1 : cnt - 16'd1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s job=%0d observed=%0h expected=%0h", tag, job_no, obs, exp);
        end
    endtask

    // Expected per-cycle trace from the first cycle after start is sampled through DONE.
    task automatic build(input int c, input int l, input int n);
        q.delete();
        for (int i = 0; i <= c; i++)
            q.push_back('{1'b0, (i < c), 1'b1, 1'b0, 16'(c - i), 4'd0});
        for (int k = 0; k < n; k++) begin
            for (int v = 0; v <= l; v++)
                q.push_back('{1'b1, (v < l), 1'b1, 1'b0, 16'(v), 4'(k)});
            for (int v = l; v >= 0; v--)
                q.push_back('{1'b0, (v > 0), 1'b1, 1'b0, 16'(v), 4'(k)});
        end
        q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 4'(n)});
    endtask

    task automatic chk_entry(input string p, input exp_t e);
        chk({p, ".s"}, {15'd0, s}, {15'd0, e.s});
        chk({p, ".cnt_en"}, {15'd0, cnt_en}, {15'd0, e.en});
        chk({p, ".busy"}, {15'd0, busy}, {15'd0, e.busy});
        chk({p, ".done"}, {15'd0, done}, {15'd0, e.done});
        chk({p, ".cnt"}, cnt, e.cnt);
        chk({p, ".sweep_idx"}, {12'd0, sweep_idx}, {12'd0, e.idx});
    endtask

    // Called just after a negedge. abort_at/rst_at index the trace (-1 = never).
    task automatic run_job(input int c, input int l, input int n, input bit do_load,
                           input int abort_at, input int rst_at);
        exp_t e;
        job_no++;
        build(c, l, n);
        if (do_load) begin
            load     = 1'b1;
            load_val = 16'(c);
            @(negedge clk);
            load = 1'b0;
        end
        start     = 1'b1;
        limit_in  = 16'(l);
        sweeps_in = 4'(n);
        @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            if (k == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
                #1;
                e.en = 1'b0;
                chk_entry("abort_cycle", e);
                @(negedge clk);
                abort = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    chk("abort_busy", {15'd0, busy}, 16'd0);
                    chk("abort_done", {15'd0, done}, 16'd0);
                    chk("abort_idx_hold", {12'd0, sweep_idx}, {12'd0, e.idx});
                    chk("abort_cnt_hold", cnt, e.cnt);
                    @(negedge clk);
                end
                return;
            end
            chk_entry($sformatf("cyc%0d", k), e);
            if (k == rst_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_s", {15'd0, s}, 16'd0);
                chk("rst_cnt_en", {15'd0, cnt_en}, 16'd0);
                chk("rst_busy", {15'd0, busy}, 16'd0);
                chk("rst_done", {15'd0, done}, 16'd0);
                chk("rst_idx", {12'd0, sweep_idx}, 16'd0);
                #2;
                rst_n = 1'b1;
                return;
            end
            if (e.done) begin
                start = 1'b0;
            end else begin
                start     = 1'($urandom);
                limit_in  = 16'($urandom);
                sweeps_in = 4'($urandom);
            end
            @(negedge clk);
        end
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_done", {15'd0, done}, 16'd0);
        chk("idle_cnt_en", {15'd0, cnt_en}, 16'd0);
        chk("idle_s", {15'd0, s}, 16'd0);
        chk("idle_idx", {12'd0, sweep_idx}, {12'd0, 4'(n)});
    endtask

    initial begin
        int c, l, n, blen;
        total     = 0;
        bad       = 0;
        job_no    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        limit_in  = 16'd0;
        sweeps_in = 4'd0;
        load      = 1'b0;
        load_val  = 16'd0;
        #1;
        chk("reset_s", {15'd0, s}, 16'd0);
        chk("reset_cnt_en", {15'd0, cnt_en}, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);
        chk("reset_idx", {12'd0, sweep_idx}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sweep 0->3->0, done ten edges after start.
        run_job(0, 3, 1, 1'b1, -1, -1);
        // Home from 5, two sweeps of limit 2.
        run_job(5, 2, 2, 1'b1, -1, -1);
        // Zero limit: counter never enabled.
        run_job(0, 0, 3, 1'b1, -1, -1);
        // Zero sweeps straight from home.
        run_job(0, 7, 0, 1'b1, -1, -1);
        // Abort in UP with the counter at 2.
        run_job(0, 4, 1, 1'b1, 3, -1);

        // Abort together with start in IDLE must not launch a job.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_start_busy", {15'd0, busy}, 16'd0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_start_busy2", {15'd0, busy}, 16'd0);

        // Reset mid-DOWN, then a job accepted on the first edge after release.
        run_job(0, 3, 2, 1'b1, -1, 6);
        run_job(int'(cnt), 2, 1, 1'b0, -1, -1);

        // Randomized jobs, some with an abort somewhere in the busy phase.
        for (int r = 0; r < 10; r++) begin
            c    = $urandom_range(0, 12);
            l    = $urandom_range(0, 10);
            n    = $urandom_range(0, 15);
            blen = c + 1 + n * (2 * l + 2);
            if (r % 4 == 3) run_job(c, l, n, 1'b1, $urandom_range(0, blen - 1), -1);
            else            run_job(c, l, n, 1'b1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("FAIL timeout job=%0d observed=running expected=finished", job_no);
        $fatal(1, "timeout");
    end

endmodule
